hp_axi_burst_splitter: RTL
==========================

Name: hp_axi_burst_splitter

Overview:
- Sits between the MIDAS simulator's host master port and the Zynq S_AXI HP slave port (DDR).
- Converts the simulator's AXI4 bursts (up to 256 beats) into AXI3-legal sub-bursts: at most MAX_BEATS beats each, never crossing a 4 KB boundary.
- Applies the DDR window remap and merges the per-sub-burst responses back into one upstream transaction.
- Handles one outstanding burst per direction; read and write paths are independent.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, data width.
- ID_W, 6, AXI ID width.
- MAX_BEATS, 16, maximum beats per downstream sub-burst (AXI3 limit).
- REMAP_HI, 4'h1, value placed in downstream address bits [31:28].

Ports:
- clk  in  1  host clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_ar_{valid,addr,id,len,size}  in  1,ADDR_W,ID_W,8,3  upstream read address.
- s_ar_ready  out  1.
- s_r_{valid,data,id,last,resp}  out  1,DATA_W,ID_W,1,2  upstream read data.
- s_r_ready  in  1.
- s_aw_{valid,addr,id,len,size}  in  1,ADDR_W,ID_W,8,3  upstream write address.
- s_aw_ready  out  1.
- s_w_{valid,data,last}  in  1,DATA_W,1  upstream write data.
- s_w_ready  out  1.
- s_b_{valid,id,resp}  out  1,ID_W,2  upstream write response.
- s_b_ready  in  1.
- m_ar_{valid,addr,id,len,size}  out  1,ADDR_W,ID_W,4,3  downstream read address.
- m_ar_ready  in  1.
- m_r_{valid,data,id,last,resp}  in  1,DATA_W,ID_W,1,2.
- m_r_ready  out  1.
- m_aw_{valid,addr,id,len,size}  out  1,ADDR_W,ID_W,4,3.
- m_aw_ready  in  1.
- m_w_{valid,data,last}  out  1,DATA_W,1.
- m_w_ready  in  1.
- m_b_{valid,id,resp}  in  1,ID_W,2.
- m_b_ready  out  1.

Behaviour:
- Reset: reset_n is asynchronous, active-low. While reset is asserted:
  - all valid outputs are 0, and all address, data, len and resp outputs are 0;
  - both FSMs are in IDLE, so s_ar_ready = s_aw_ready = 1;
  - s_w_ready, m_r_ready and m_b_ready are 0.
  - Asserting reset mid-burst abandons the burst immediately; there is no drain.
- Address handling:
  - Downstream address is {REMAP_HI, addr[27:0]}; bits below size are cleared.
  - Beats to the 4 KB boundary = (4096 - addr[11:0]) >> size, range 1..4096.
  - Sub-burst beats = min(remaining, MAX_BEATS, beats to boundary).
  - m_*_len = sub-burst beats - 1.
  - After each sub-burst: addr += beats << size; remaining -= beats.
  - size, and the latched upstream id, are forwarded unchanged on every sub-burst.
- Read FSM (R_IDLE, R_ADDR, R_DATA):
  - R_IDLE: s_ar_ready = 1. On handshake, latch addr/id/len/size, set remaining = len + 1, go to R_ADDR. m_ar_valid rises the next cycle.
  - R_ADDR: m_ar_valid held with stable fields until m_ar_ready, then go to R_DATA.
  - R_DATA: combinational pass-through: s_r_valid = m_r_valid, m_r_ready = s_r_ready; data and resp pass through; s_r_id = latched id.
  - s_r_last = m_r_last AND this is the final sub-burst.
  - On the m_r_last handshake: go to R_ADDR if remaining > 0, else R_IDLE.
  - Outside R_DATA, m_r_ready = 0.
- Write FSM (W_IDLE, W_ADDR, W_DATA, W_BWAIT, W_RESP):
  - W_IDLE: s_aw_ready = 1. Latch fields as for reads; go to W_ADDR.
  - W_ADDR: m_aw_valid held until m_aw_ready, then go to W_DATA.
  - W_DATA: pass-through: m_w_valid = s_w_valid, s_w_ready = m_w_ready, data passes through.
  - A beat counter drives m_w_last on the sub-burst's final beat. s_w_last is ignored. Outside W_DATA, s_w_ready = 0.
  - W_DATA exits to W_BWAIT after the final beat of the sub-burst.
  - W_BWAIT: m_b_ready = 1. On m_b handshake, resp_acc = max(resp_acc, m_b_resp); resp_acc is cleared at AW accept. Go to W_ADDR if remaining > 0, else W_RESP.
  - W_RESP: s_b_valid = 1 with s_b_id = latched id and s_b_resp = resp_acc. It is held until s_b_ready, then go to W_IDLE.
- Sub-burst issue is serial: the next AR/AW is issued only after the previous sub-burst's data (and, for writes, its B) completes.
- Latency:
  - Upstream address handshake to m_*_valid: 1 cycle.
  - Final m_b handshake to s_b_valid: 1 cycle.
  - Data paths: 0 cycles.
- Downstream m_r_id and m_b_id are ignored.

Test Plan:
- Short read: AR addr 0x0000_1000, len 3, size 3 -> one m_ar with addr 0x1000_1000, len 3; 4 beats pass through; s_r_last only on beat 4.
- Long read: AR addr 0x0000_2000, len 39 -> m_ar len 15/15/7 at 0x1000_2000 / 0x1000_2080 / 0x1000_2100; 40 upstream beats; s_r_last only on beat 40.
- 4 KB crossing: AR addr 0x0000_0FE0, len 7, size 3 -> m_ar len 3 at 0x1000_0FE0, then len 3 at 0x1000_1000.
- Write merge: AW addr 0x0800_0040, len 19, id 0x2A -> m_aw len 15 at 0x1800_0040, then len 3 at 0x1800_00C0; m_w_last on beats 16 and 20. m_b resp OKAY then SLVERR -> exactly one s_b with resp 2'b10, id 0x2A.
- Backpressure: s_r_ready toggled 0/1 every cycle during R_DATA -> m_r_ready mirrors it, no beat lost or duplicated; s_ar_ready = 0 until the burst completes.
- Reset mid-write: reset_n driven low during W_DATA -> all valids 0 in the same cycle; after release, s_aw_ready = 1 and a fresh len 0 write completes normally.

Source files
------------

// File: rtl/hp_axi_burst_splitter.sv
// rtl/hp_axi_burst_splitter.sv - AXI4 to AXI3 burst splitter with DDR window remap for the HP port
//
// Splits upstream AXI4 bursts (up to 256 beats) into downstream sub-bursts of
// at most MAX_BEATS beats that never cross a 4 KB boundary. The downstream
// address carries REMAP_HI in bits [31:28]. One burst per direction is in
// flight; read and write paths are independent.
//
// Ports:
//   clk, reset_n             host clock, asynchronous active-low reset
//   s_ar_* / s_r_*           upstream read address / read data
//   s_aw_* / s_w_* / s_b_*   upstream write address / data / response
//   m_ar_* / m_r_*           downstream read address / read data
//   m_aw_* / m_w_* / m_b_*   downstream write address / data / response
module hp_axi_burst_splitter #(
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 64,
  parameter int         ID_W      = 6,
  parameter int         MAX_BEATS = 16,
  parameter logic [3:0] REMAP_HI  = 4'h1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_ar_valid,
  input  logic [ADDR_W-1:0] s_ar_addr,
  input  logic [ID_W-1:0]   s_ar_id,
  input  logic [7:0]        s_ar_len,
  input  logic [2:0]        s_ar_size,
  output logic              s_ar_ready,
  output logic              s_r_valid,
  output logic [DATA_W-1:0] s_r_data,
  output logic [ID_W-1:0]   s_r_id,
  output logic              s_r_last,
  output logic [1:0]        s_r_resp,
  input  logic              s_r_ready,
  input  logic              s_aw_valid,
  input  logic [ADDR_W-1:0] s_aw_addr,
  input  logic [ID_W-1:0]   s_aw_id,
  input  logic [7:0]        s_aw_len,
  input  logic [2:0]        s_aw_size,
  output logic              s_aw_ready,
  input  logic              s_w_valid,
  input  logic [DATA_W-1:0] s_w_data,
  input  logic              s_w_last,
  output logic              s_w_ready,
  output logic              s_b_valid,
  output logic [ID_W-1:0]   s_b_id,
  output logic [1:0]        s_b_resp,
  input  logic              s_b_ready,
  output logic              m_ar_valid,
  output logic [ADDR_W-1:0] m_ar_addr,
  output logic [ID_W-1:0]   m_ar_id,
  output logic [3:0]        m_ar_len,
  output logic [2:0]        m_ar_size,
  input  logic              m_ar_ready,
  input  logic              m_r_valid,
  input  logic [DATA_W-1:0] m_r_data,
  input  logic [ID_W-1:0]   m_r_id,
  input  logic              m_r_last,
  input  logic [1:0]        m_r_resp,
  output logic              m_r_ready,
  output logic              m_aw_valid,
  output logic [ADDR_W-1:0] m_aw_addr,
  output logic [ID_W-1:0]   m_aw_id,
  output logic [3:0]        m_aw_len,
  output logic [2:0]        m_aw_size,
  input  logic              m_aw_ready,
  output logic              m_w_valid,
  output logic [DATA_W-1:0] m_w_data,
  output logic              m_w_last,
  input  logic              m_w_ready,
  input  logic              m_b_valid,
  input  logic [ID_W-1:0]   m_b_id,
  input  logic [1:0]        m_b_resp,
  output logic              m_b_ready
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_BWAIT, W_RESP} wr_state_e;

  // Beats in the next sub-burst: limited by what is left, MAX_BEATS and the
  // distance to the next 4 KB page. off is already size-aligned, so the
  // page distance is always at least one beat.
  function automatic logic [8:0] sub_beats(input logic [11:0] off, input logic [8:0] rem,
                                           input logic [2:0] sz);
    logic [12:0] to_bnd;
    logic [8:0]  b;
    to_bnd = (13'd4096 - {1'b0, off}) >> sz;
    b = rem;
    if (b > 9'(MAX_BEATS)) b = 9'(MAX_BEATS);
    if ({4'd0, b} > to_bnd) b = to_bnd[8:0];
    return b;
  endfunction

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a, input logic [2:0] sz);
    return a & ~((ADDR_W'(1) << sz) - ADDR_W'(1));
  endfunction

  function automatic logic [ADDR_W-1:0] remap(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = a;
    r[31:28] = REMAP_HI;
    return r;
  endfunction

  // ---------------- read path ----------------
  rd_state_e         rd_state_q;
  logic [ADDR_W-1:0] rd_addr_q, rd_src_addr, rd_addr_d;
  logic [8:0]        rd_rem_q, rd_src_rem, rd_rem_d, rd_beats;
  logic [2:0]        rd_size_q, rd_src_size;
  logic [ID_W-1:0]   rd_id_q;
  logic              m_ar_valid_q;
  logic [ADDR_W-1:0] m_ar_addr_q;
  logic [3:0]        m_ar_len_q;

  // In IDLE the first sub-burst is sized straight from the AR inputs so
  // that m_ar_valid can rise one cycle after the upstream handshake.
  always_comb begin
    if (rd_state_q == R_IDLE) begin
      rd_src_addr = align(s_ar_addr, s_ar_size);
      rd_src_rem  = {1'b0, s_ar_len} + 9'd1;
      rd_src_size = s_ar_size;
    end else begin
      rd_src_addr = rd_addr_q;
      rd_src_rem  = rd_rem_q;
      rd_src_size = rd_size_q;
    end
    rd_beats  = sub_beats(rd_src_addr[11:0], rd_src_rem, rd_src_size);
    rd_addr_d = rd_src_addr + (ADDR_W'(rd_beats) << rd_src_size);
    rd_rem_d  = rd_src_rem - rd_beats;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_q   <= R_IDLE;
      rd_addr_q    <= '0;
      rd_rem_q     <= '0;
      rd_size_q    <= '0;
      rd_id_q      <= '0;
      m_ar_valid_q <= 1'b0;
      m_ar_addr_q  <= '0;
      m_ar_len_q   <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: if (s_ar_valid) begin
          rd_id_q      <= s_ar_id;
          rd_size_q    <= s_ar_size;
          rd_addr_q    <= rd_addr_d;
          rd_rem_q     <= rd_rem_d;
          m_ar_valid_q <= 1'b1;
          m_ar_addr_q  <= remap(rd_src_addr);
          m_ar_len_q   <= 4'(rd_beats - 9'd1);
          rd_state_q   <= R_ADDR;
        end
        R_ADDR: if (m_ar_ready) begin
          m_ar_valid_q <= 1'b0;
          rd_state_q   <= R_DATA;
        end
        R_DATA: if (m_r_valid && s_r_ready && m_r_last) begin
          if (rd_rem_q != 9'd0) begin
            rd_addr_q    <= rd_addr_d;
            rd_rem_q     <= rd_rem_d;
            m_ar_valid_q <= 1'b1;
            m_ar_addr_q  <= remap(rd_src_addr);
            m_ar_len_q   <= 4'(rd_beats - 9'd1);
            rd_state_q   <= R_ADDR;
          end else begin
            rd_state_q   <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  logic rd_data;
  assign rd_data    = (rd_state_q == R_DATA);
  assign s_ar_ready = (rd_state_q == R_IDLE);
  assign m_ar_valid = m_ar_valid_q;
  assign m_ar_addr  = m_ar_addr_q;
  assign m_ar_len   = m_ar_len_q;
  assign m_ar_id    = rd_id_q;
  assign m_ar_size  = rd_size_q;
  assign s_r_valid  = rd_data && m_r_valid;
  assign m_r_ready  = rd_data && s_r_ready;
  assign s_r_data   = rd_data ? m_r_data : '0;
  assign s_r_resp   = rd_data ? m_r_resp : 2'b00;
  assign s_r_id     = rd_data ? rd_id_q : '0;
  // rem is already decremented at issue, so zero means this is the final sub-burst.
  assign s_r_last   = rd_data && m_r_last && (rd_rem_q == 9'd0);

  // ---------------- write path ----------------
  wr_state_e         wr_state_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_src_addr, wr_addr_d;
  logic [8:0]        wr_rem_q, wr_src_rem, wr_rem_d, wr_beats;
  logic [2:0]        wr_size_q, wr_src_size;
  logic [ID_W-1:0]   wr_id_q;
  logic              m_aw_valid_q;
  logic [ADDR_W-1:0] m_aw_addr_q;
  logic [3:0]        m_aw_len_q;
  logic [3:0]        w_cnt_q;
  logic [1:0]        resp_acc_q, resp_max;
  logic              wr_data, w_last_beat;

  always_comb begin
    if (wr_state_q == W_IDLE) begin
      wr_src_addr = align(s_aw_addr, s_aw_size);
      wr_src_rem  = {1'b0, s_aw_len} + 9'd1;
      wr_src_size = s_aw_size;
    end else begin
      wr_src_addr = wr_addr_q;
      wr_src_rem  = wr_rem_q;
      wr_src_size = wr_size_q;
    end
    wr_beats  = sub_beats(wr_src_addr[11:0], wr_src_rem, wr_src_size);
    wr_addr_d = wr_src_addr + (ADDR_W'(wr_beats) << wr_src_size);
    wr_rem_d  = wr_src_rem - wr_beats;
    // Worst response wins: DECERR > SLVERR > EXOKAY > OKAY.
    resp_max  = (m_b_resp > resp_acc_q) ? m_b_resp : resp_acc_q;
  end

  assign wr_data     = (wr_state_q == W_DATA);
  assign w_last_beat = wr_data && (w_cnt_q == m_aw_len_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state_q   <= W_IDLE;
      wr_addr_q    <= '0;
      wr_rem_q     <= '0;
      wr_size_q    <= '0;
      wr_id_q      <= '0;
      m_aw_valid_q <= 1'b0;
      m_aw_addr_q  <= '0;
      m_aw_len_q   <= '0;
      w_cnt_q      <= '0;
      resp_acc_q   <= 2'b00;
    end else begin
      case (wr_state_q)
        W_IDLE: if (s_aw_valid) begin
          wr_id_q      <= s_aw_id;
          wr_size_q    <= s_aw_size;
          wr_addr_q    <= wr_addr_d;
          wr_rem_q     <= wr_rem_d;
          m_aw_valid_q <= 1'b1;
          m_aw_addr_q  <= remap(wr_src_addr);
          m_aw_len_q   <= 4'(wr_beats - 9'd1);
          w_cnt_q      <= '0;
          resp_acc_q   <= 2'b00;
          wr_state_q   <= W_ADDR;
        end
        W_ADDR: if (m_aw_ready) begin
          m_aw_valid_q <= 1'b0;
          wr_state_q   <= W_DATA;
        end
        W_DATA: if (s_w_valid && m_w_ready) begin
          if (w_last_beat) begin
            w_cnt_q    <= '0;
            wr_state_q <= W_BWAIT;
          end else begin
            w_cnt_q    <= w_cnt_q + 4'd1;
          end
        end
        W_BWAIT: if (m_b_valid) begin
          resp_acc_q <= resp_max;
          if (wr_rem_q != 9'd0) begin
            wr_addr_q    <= wr_addr_d;
            wr_rem_q     <= wr_rem_d;
            m_aw_valid_q <= 1'b1;
            m_aw_addr_q  <= remap(wr_src_addr);
            m_aw_len_q   <= 4'(wr_beats - 9'd1);
            wr_state_q   <= W_ADDR;
          end else begin
            wr_state_q   <= W_RESP;
          end
        end
        W_RESP: if (s_b_ready) wr_state_q <= W_IDLE;
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  assign s_aw_ready = (wr_state_q == W_IDLE);
  assign m_aw_valid = m_aw_valid_q;
  assign m_aw_addr  = m_aw_addr_q;
  assign m_aw_len   = m_aw_len_q;
  assign m_aw_id    = wr_id_q;
  assign m_aw_size  = wr_size_q;
  assign m_w_valid  = wr_data && s_w_valid;
  assign s_w_ready  = wr_data && m_w_ready;
  assign m_w_data   = wr_data ? s_w_data : '0;
  assign m_w_last   = w_last_beat;
  assign m_b_ready  = (wr_state_q == W_BWAIT);
  assign s_b_valid  = (wr_state_q == W_RESP);
  assign s_b_resp   = s_b_valid ? resp_acc_q : 2'b00;
  assign s_b_id     = s_b_valid ? wr_id_q : '0;

  // Downstream IDs and the upstream WLAST are not needed: the splitter
  // tracks beats and owns the single outstanding ID itself.
  logic unused_ok;
  assign unused_ok = ^{m_r_id, m_b_id, s_w_last};

endmodule
